frame_buffer_pingpong: RTL
==========================

// Module: frame_buffer_pingpong
// PURPOSE
//  Double-buffered (ping-pong) LED-panel frame store: host side writes the back bank, display scanner reads the front bank.
//  Per-channel write mask; bank swap is requested by host and committed only at display frame boundary (tear-free).
//  Optional hardware clear of the new back bank after swap. Sits between the frame loader and the HUB75 scan driver.
// PARAMETERS
//  WIDTH        128  panel width in pixels
//  HEIGHT       64   panel height in pixels
//  CHAINED      1    panels in chain
//  BPC          4    bits per colour channel
//  CHANNELS     3    colour channels per pixel (R,G,B)
//  CLEAR_VALUE  0    pixel value (BPP bits) written by clear sweep
//  localparams: BPP=BPC*CHANNELS; DEPTH=CHAINED*WIDTH*HEIGHT; AW=$clog2(DEPTH)
// PORTS
//  clk            in   1         system clock
//  rst            in   1         asynchronous reset, active-high
//  wr_en          in   1         write strobe (honoured only when wr_ready=1)
//  wr_addr        in   AW        back-bank pixel address
//  wr_data        in   BPP       pixel, channel k = wr_data[k*BPC +: BPC]
//  wr_mask        in   CHANNELS  per-channel write enable
//  wr_ready       out  1         1 = host writes accepted
//  swap_req       in   1         pulse: request bank swap
//  clear_on_swap  in   1         sampled with accepted swap_req: clear new back bank
//  swap_pending   out  1         1 while swap requested or clear running
//  swap_done      out  1         1-cycle pulse on the edge front_bank toggles
//  front_bank     out  1         bank currently displayed
//  frame_done     in   1         pulse from scanner: last pixel of frame read
//  rd_en          in   1         display read strobe
//  rd_addr        in   AW        front-bank pixel address
//  rd_data        out  BPP       read data, registered
//  rd_valid       out  1         1 cycle after rd_en
// BEHAVIOUR
//  Reset: state=ACTIVE, front_bank=0, wr_ready=1, swap_pending=0, swap_done=0, rd_data=0, rd_valid=0, clear counter=0.
//   Memory contents not reset. Reset mid-CLEAR aborts sweep; back bank contents undefined.
//  Storage: 2*DEPTH entries/channel, physical addr={bank,addr}. Host writes bank ~front_bank, reads bank front_bank.
//  Write: on edge with wr_en&wr_ready&(wr_addr<DEPTH), channel k updated iff wr_mask[k]; masked channels keep old value.
//   wr_addr>=DEPTH: write dropped silently.
//  Read: latency 1. rd_en at cycle N -> rd_data/rd_valid at N+1; bank = front_bank value at cycle N.
//   rd_addr>=DEPTH -> rd_data=CLEAR_VALUE. rd_en=0 -> rd_valid=0, rd_data holds last value.
//  FSM: ACTIVE, PENDING, CLEARING.  swap_pending=(state!=ACTIVE); wr_ready=(state==ACTIVE).
//   ACTIVE:  swap_req -> PENDING, latch clear_on_swap. Write in same cycle as swap_req is accepted.
//            frame_done in ACTIVE (incl. same cycle as swap_req) ignored.
//   PENDING: frame_done -> toggle front_bank, pulse swap_done; -> CLEARING if latched clear else ACTIVE.
//            swap_req ignored; wr_en ignored.
//   CLEARING: counter 0..DEPTH-1 writes CLEAR_VALUE (all channels) to back bank, one entry/clk;
//            after entry DEPTH-1 -> ACTIVE, counter=0. Duration exactly DEPTH cycles. swap_req/wr_en ignored.
//  Reads never hit back bank, so read/write and read/clear never collide. Read at toggle edge uses old bank.
//  No read-during-write forwarding needed (different banks always).
// STRUCTURE
//  fb_params.vh: default WIDTH/HEIGHT/CHAINED/BPC/CHANNELS, FSM state encodings (2-bit).
//  Sub-module fb_channel_ram: BPC-wide, 2*DEPTH-deep, 1 write + 1 registered read port;
//   generated CHANNELS times, write enable = mask[k] or clear.
//  Top holds FSM, bank bit, clear counter, address muxing, range checks.
// TESTING
//  1 Write 0xABC @5, swap (no clear), frame_done, read @5 -> 0xABC one cycle after rd_en, rd_valid=1.
//  2 Pixel @7=0xFFF in back; write 0x000 mask=3'b010 -> read back after swap = 0xF0F.
//  3 swap_req + frame_done same cycle -> no toggle; next frame_done -> toggle, swap_done 1 cycle, wr_ready 0 while PENDING.
//  4 clear_on_swap=1, CLEAR_VALUE=0x123: after swap wr_ready low exactly DEPTH cycles; swap again, every read = 0x123.
//  5 rd_en on toggle edge returns old-bank data; next read returns new-bank data; wr_addr=DEPTH (non-pow2 cfg) dropped.
//  6 Assert rst mid-CLEARING -> front_bank=0, wr_ready=1, swap_pending=0, rd_valid=0 immediately (async).

Source files
------------

// File: rtl/frame_buffer_pingpong_pkg.sv
// Shared definitions for the ping-pong LED frame store: default geometry,
// pixel format and the bank-swap controller state encoding.
package frame_buffer_pingpong_pkg;

    // Default panel geometry and pixel format
    localparam int DEF_WIDTH    = 128;
    localparam int DEF_HEIGHT   = 64;
    localparam int DEF_CHAINED  = 1;
    localparam int DEF_BPC      = 4;
    localparam int DEF_CHANNELS = 3;

    // Swap controller states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,  // host owns back bank, writes accepted
        ST_PENDING  = 2'd1,  // swap requested, waiting for end of displayed frame
        ST_CLEARING = 2'd2   // sweeping CLEAR_VALUE through the new back bank
    } fb_state_t;

    // Number of pixel entries held per bank
    function automatic int fb_depth(input int width, input int height, input int chained);
        return chained * width * height;
    endfunction

endpackage

// File: rtl/frame_buffer_pingpong_channel_ram.sv
// One colour channel of the frame store: simple dual-port memory holding
// both banks, one write port and one registered read port.
module frame_buffer_pingpong_channel_ram #(
    parameter int DW = 4,   // bits per channel
    parameter int PW = 5    // physical address width ({bank, pixel address})
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [PW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<PW)-1];
    logic [DW-1:0] rdata_reg;

    // Write port plus read-enabled output register (maps onto block RAM)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered LED panel frame store. The host fills the back bank while the
// scanner reads the front bank; a requested swap only takes effect at the
// scanner's frame boundary, optionally followed by a clear sweep of the new
// back bank.
module frame_buffer_pingpong
    import frame_buffer_pingpong_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int CHAINED  = DEF_CHAINED,
    parameter int BPC      = DEF_BPC,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter logic [BPC*CHANNELS-1:0] CLEAR_VALUE = '0,
    localparam int BPP     = BPC * CHANNELS,
    localparam int DEPTH   = fb_depth(WIDTH, HEIGHT, CHAINED),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [BPP-1:0]      wr_data,
    input  logic [CHANNELS-1:0] wr_mask,
    output logic                wr_ready,
    input  logic                swap_req,
    input  logic                clear_on_swap,
    output logic                swap_pending,
    output logic                swap_done,
    output logic                front_bank,
    input  logic                frame_done,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [BPP-1:0]      rd_data,
    output logic                rd_valid
);

    // Range limit widened by one bit so non-power-of-two depths compare cleanly
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fb_state_t     state_reg;
    logic          front_bank_reg;
    logic          clear_latched_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          swap_done_reg;
    logic          wr_ready_reg;
    logic          swap_pending_reg;

    logic          rd_valid_reg;
    logic          rd_primed_reg;   // set once any read has completed since reset
    logic          rd_oor_reg;      // last completed read was outside the panel

    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_accept;
    logic          clearing;
    logic [AW:0]   ram_waddr;
    logic [AW:0]   ram_raddr;
    logic          ram_re;
    logic [BPP-1:0] ram_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
    assign wr_accept   = wr_en & wr_ready_reg & wr_in_range;
    assign clearing    = (state_reg == ST_CLEARING);

    // Writes and the clear sweep always target the back bank; reads the front bank
    assign ram_waddr = {~front_bank_reg, (clearing ? clr_cnt_reg : wr_addr)};
    assign ram_raddr = {front_bank_reg, rd_addr};
    assign ram_re    = rd_en & rd_in_range;

    // Swap controller: waits for the frame boundary, flips banks, optionally clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_ACTIVE;
            front_bank_reg    <= 1'b0;
            clear_latched_reg <= 1'b0;
            clr_cnt_reg       <= '0;
            swap_done_reg     <= 1'b0;
            wr_ready_reg      <= 1'b1;
            swap_pending_reg  <= 1'b0;
        end else begin
            swap_done_reg <= 1'b0;
            case (state_reg)
                ST_ACTIVE: begin
                    // frame_done is meaningless here: nothing is waiting to swap
                    if (swap_req) begin
                        state_reg         <= ST_PENDING;
                        clear_latched_reg <= clear_on_swap;
                        wr_ready_reg      <= 1'b0;
                        swap_pending_reg  <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (frame_done) begin
                        front_bank_reg <= ~front_bank_reg;
                        swap_done_reg  <= 1'b1;
                        if (clear_latched_reg) begin
                            state_reg   <= ST_CLEARING;
                            clr_cnt_reg <= '0;
                        end else begin
                            state_reg        <= ST_ACTIVE;
                            wr_ready_reg     <= 1'b1;
                            swap_pending_reg <= 1'b0;
                        end
                    end
                end
                ST_CLEARING: begin
                    if (clr_cnt_reg == LAST_IDX) begin
                        clr_cnt_reg      <= '0;
                        state_reg        <= ST_ACTIVE;
                        wr_ready_reg     <= 1'b1;
                        swap_pending_reg <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg        <= ST_ACTIVE;
                    wr_ready_reg     <= 1'b1;
                    swap_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    // Read-side bookkeeping: valid strobe and the flags that shape rd_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg  <= 1'b0;
            rd_primed_reg <= 1'b0;
            rd_oor_reg    <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_primed_reg <= 1'b1;
                rd_oor_reg    <= ~rd_in_range;
            end
        end
    end

    // One RAM per channel; clear overrides the mask and writes every channel
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic           chan_we;
            logic [BPC-1:0] chan_wdata;

            assign chan_we    = clearing | (wr_accept & wr_mask[gi]);
            assign chan_wdata = clearing ? CLEAR_VALUE[gi*BPC +: BPC]
                                         : wr_data[gi*BPC +: BPC];

            frame_buffer_pingpong_channel_ram #(
                .DW (BPC),
                .PW (AW + 1)
            ) u_ram (
                .clk   (clk),
                .we    (chan_we),
                .waddr (ram_waddr),
                .wdata (chan_wdata),
                .re    (ram_re),
                .raddr (ram_raddr),
                .rdata (ram_q[gi*BPC +: BPC])
            );
        end
    endgenerate

    // Output data: zero until the first read, fill value for off-panel reads
    always_comb begin
        rd_data = ram_q;
        if (!rd_primed_reg) begin
            rd_data = '0;
        end else if (rd_oor_reg) begin
            rd_data = CLEAR_VALUE;
        end
    end

    assign wr_ready     = wr_ready_reg;
    assign swap_pending = swap_pending_reg;
    assign swap_done    = swap_done_reg;
    assign front_bank   = front_bank_reg;
    assign rd_valid     = rd_valid_reg;

endmodule
